// File: rtl/uart_mem_loader_pkg.sv
// Shared definitions for the UART memory loader: default geometry and the
// FSM state encoding. The encoding values are fixed so that processor-side
// memory-init code can interpret them.
// Optional feature macro: LOADER_CHECKSUM_EN (adds the CHECK state).
package uart_mem_loader_pkg;

    localparam int LDR_DATA_WIDTH = 8;
    localparam int LDR_WORD_WIDTH = 16;
    localparam int LDR_ADDR_WIDTH = 12;
    localparam int LDR_MEM_DEPTH  = 4096;

    // Encoding is explicit so DONE keeps the same code with or without CHECK.
    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WAIT_START = 3'd1,
        ST_WAIT_END   = 3'd2,
        ST_WRITE      = 3'd3,
`ifdef LOADER_CHECKSUM_EN
        ST_CHECK      = 3'd4,
`endif
        ST_DONE       = 3'd5
    } state_t;

    // Number of received bytes that make up one memory word.
    function automatic int lanes_per_word(input int data_width, input int word_width);
        return word_width / data_width;
    endfunction

endpackage

// File: rtl/uart_mem_loader_byte_packer.sv
// loader_byte_packer: byte-lane index counter and word assembly register.
// Bytes fill the word little-endian (first byte in the LSBs). word_nxt shows
// the word as it will look once the current byte is written, so the parent
// can register a complete word on the same edge that captures its last byte.
module loader_byte_packer
    import uart_mem_loader_pkg::*;
#(
    parameter int DATA_WIDTH = LDR_DATA_WIDTH,
    parameter int WORD_WIDTH = LDR_WORD_WIDTH
) (
    input  logic                  clk,
    input  logic                  rstN,
    input  logic                  clr_idx,
    input  logic                  capture,
    input  logic [DATA_WIDTH-1:0] byte_in,
    output logic [WORD_WIDTH-1:0] word_nxt,
    output logic                  last_lane
);

    localparam int LANES = lanes_per_word(DATA_WIDTH, WORD_WIDTH);
    localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);

    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [WORD_WIDTH-1:0] word_q, word_d;
    logic [WORD_WIDTH-1:0] word_ins;

    assign last_lane = (idx_q == LAST_IDX);
    assign word_nxt  = word_ins;

    // Insert the incoming byte into its lane and advance the lane index.
    always_comb begin
        word_ins = word_q;
        word_ins[int'(idx_q) * DATA_WIDTH +: DATA_WIDTH] = byte_in;
        word_d = capture ? word_ins : word_q;
        idx_d  = idx_q;
        if (clr_idx) begin
            idx_d = '0;
        end else if (capture && !last_lane) begin
            idx_d = idx_q + 1'b1;
        end
    end

    // Lane index and assembly register; a reset drops any partial word.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            idx_q  <= '0;
            word_q <= '0;
        end else begin
            idx_q  <= idx_d;
            word_q <= word_d;
        end
    end

endmodule

// File: rtl/uart_mem_loader.sv
// uart_mem_loader: collects bytes from a UART receiver handshake, packs them
// into words and writes MEM_DEPTH words to consecutive addresses from 0.
// Optional feature macro: LOADER_CHECKSUM_EN -- one trailer byte after the
// last word is compared with the XOR of all data bytes; chk_err flags a
// mismatch. Without the macro chk_err is tied low.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// IDLE        | after reset; waiting for start_load
// WAIT_START  | waiting for rx_new_byte (receiver saw a start bit)
// WAIT_END    | waiting for rx_ready; captures rx_data on its first high cycle
// WRITE       | single-cycle memory write of the assembled word
// CHECK       | (checksum build) receives and compares the trailer byte
// DONE        | load complete; start_load begins a new load
module uart_mem_loader
    import uart_mem_loader_pkg::*;
#(
    parameter int DATA_WIDTH = LDR_DATA_WIDTH,
    parameter int WORD_WIDTH = LDR_WORD_WIDTH,
    parameter int ADDR_WIDTH = LDR_ADDR_WIDTH,
    parameter int MEM_DEPTH  = LDR_MEM_DEPTH
) (
    input  logic                  clk,
    input  logic                  rstN,
    input  logic                  rx_ready,
    input  logic                  rx_new_byte,
    input  logic [DATA_WIDTH-1:0] rx_data,
    input  logic                  start_load,
    output logic                  mem_wr_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [WORD_WIDTH-1:0] mem_wr_data,
    output logic                  busy,
    output logic                  done,
    output logic                  chk_err
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_DEPTH - 1);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [WORD_WIDTH-1:0] mem_wr_data_q, mem_wr_data_d;
    logic                  mem_wr_en_q, mem_wr_en_d;
    logic                  busy_c;

    logic                  pk_clr;
    logic                  pk_capture;
    logic                  pk_last;
    logic [WORD_WIDTH-1:0] pk_word_nxt;

`ifdef LOADER_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] csum_q, csum_d;
    logic                  armed_q, armed_d;
    logic                  chk_err_q, chk_err_d;
`endif

    loader_byte_packer #(
        .DATA_WIDTH (DATA_WIDTH),
        .WORD_WIDTH (WORD_WIDTH)
    ) u_packer (
        .clk       (clk),
        .rstN      (rstN),
        .clr_idx   (pk_clr),
        .capture   (pk_capture),
        .byte_in   (rx_data),
        .word_nxt  (pk_word_nxt),
        .last_lane (pk_last)
    );

    // Next-state and datapath control for the load sequence.
    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        mem_addr_d    = mem_addr_q;
        mem_wr_data_d = mem_wr_data_q;
        mem_wr_en_d   = 1'b0;
        busy_c        = 1'b0;
        pk_clr        = 1'b0;
        pk_capture    = 1'b0;
`ifdef LOADER_CHECKSUM_EN
        csum_d        = csum_q;
        armed_d       = armed_q;
        chk_err_d     = chk_err_q;
`endif
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_load) begin
                    state_d = ST_WAIT_START;
                    addr_d  = '0;
                    pk_clr  = 1'b1;
`ifdef LOADER_CHECKSUM_EN
                    csum_d    = '0;
                    armed_d   = 1'b0;
                    chk_err_d = 1'b0;
`endif
                end
            end
            ST_WAIT_START: begin
                busy_c = 1'b1;
                if (rx_new_byte) begin
                    state_d = ST_WAIT_END;
                end
            end
            ST_WAIT_END: begin
                busy_c = 1'b1;
                if (rx_ready) begin
                    pk_capture = 1'b1;
`ifdef LOADER_CHECKSUM_EN
                    csum_d = csum_q ^ rx_data;
`endif
                    if (pk_last) begin
                        // Register the write now so the strobe lands in WRITE.
                        state_d       = ST_WRITE;
                        mem_wr_en_d   = 1'b1;
                        mem_addr_d    = addr_q;
                        mem_wr_data_d = pk_word_nxt;
                    end else begin
                        state_d = ST_WAIT_START;
                    end
                end
            end
            ST_WRITE: begin
                busy_c = 1'b1;
                pk_clr = 1'b1;
                if (addr_q == LAST_ADDR) begin
`ifdef LOADER_CHECKSUM_EN
                    state_d = ST_CHECK;
`else
                    state_d = ST_DONE;
`endif
                end else begin
                    addr_d  = addr_q + 1'b1;
                    state_d = ST_WAIT_START;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            ST_CHECK: begin
                // Trailer byte uses the same start/ready handshake as data.
                busy_c = 1'b1;
                if (!armed_q) begin
                    if (rx_new_byte) begin
                        armed_d = 1'b1;
                    end
                end else if (rx_ready) begin
                    chk_err_d = (rx_data != csum_q);
                    armed_d   = 1'b0;
                    state_d   = ST_DONE;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, address and registered write-port outputs.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q       <= ST_IDLE;
            addr_q        <= '0;
            mem_addr_q    <= '0;
            mem_wr_data_q <= '0;
            mem_wr_en_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            mem_addr_q    <= mem_addr_d;
            mem_wr_data_q <= mem_wr_data_d;
            mem_wr_en_q   <= mem_wr_en_d;
        end
    end

`ifdef LOADER_CHECKSUM_EN
    // Running checksum, trailer handshake flag and mismatch flag.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            csum_q    <= '0;
            armed_q   <= 1'b0;
            chk_err_q <= 1'b0;
        end else begin
            csum_q    <= csum_d;
            armed_q   <= armed_d;
            chk_err_q <= chk_err_d;
        end
    end

    assign chk_err = chk_err_q;
`else
    assign chk_err = 1'b0;
`endif

    assign mem_wr_en   = mem_wr_en_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wr_data = mem_wr_data_q;
    assign busy        = busy_c;
    assign done        = (state_q == ST_DONE);

endmodule

// File: tb/tb_uart_mem_loader.sv
// Testbench for uart_mem_loader (DATA_WIDTH=8, WORD_WIDTH=16, MEM_DEPTH=4).
// Honours LOADER_CHECKSUM_EN when the bundle is built with it.
module tb_uart_mem_loader;

    localparam int DW     = 8;
    localparam int WW     = 16;
    localparam int AW     = 12;
    localparam int DEPTH  = 4;
    localparam int NBYTES = DEPTH * (WW / DW);

    logic          clk = 1'b0;
    logic          rstN = 1'b0;
    logic          rx_ready = 1'b1;
    logic          rx_new_byte = 1'b0;
    logic [DW-1:0] rx_data = '0;
    logic          start_load = 1'b0;
    logic          mem_wr_en;
    logic [AW-1:0] mem_addr;
    logic [WW-1:0] mem_wr_data;
    logic          busy;
    logic          done;
    logic          chk_err;

    typedef struct {
        logic [AW-1:0] addr;
        logic [WW-1:0] word;
    } wr_t;

    typedef struct {
        logic [DW-1:0] lo;
        logic [DW-1:0] hi;
        logic [AW-1:0] addr;
        logic [WW-1:0] word;
    } vec_t;

    typedef logic [DW-1:0] bytes_t [NBYTES];
    typedef wr_t words_t [DEPTH];

    wr_t exp_q[$];
    int  tests = 0;
    int  fails = 0;
    int  wr_seen = 0;

    uart_mem_loader #(
        .DATA_WIDTH (DW),
        .WORD_WIDTH (WW),
        .ADDR_WIDTH (AW),
        .MEM_DEPTH  (DEPTH)
    ) dut (
        .clk         (clk),
        .rstN        (rstN),
        .rx_ready    (rx_ready),
        .rx_new_byte (rx_new_byte),
        .rx_data     (rx_data),
        .start_load  (start_load),
        .mem_wr_en   (mem_wr_en),
        .mem_addr    (mem_addr),
        .mem_wr_data (mem_wr_data),
        .busy        (busy),
        .done        (done),
        .chk_err     (chk_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Every write strobe must match the next expected write, in order.
    always @(negedge clk) begin
        if (rstN && mem_wr_en === 1'b1) begin
            wr_seen++;
            if (exp_q.size() == 0) begin
                check("unexpected_write", {31'd0, mem_wr_en}, 32'd0);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_addr", {20'd0, mem_addr}, {20'd0, e.addr});
                check("wr_data", {16'd0, mem_wr_data}, {16'd0, e.word});
            end
        end
    end

    // Reference: byte 2k is the low byte and 2k+1 the high byte of word k.
    task automatic model_load(input bytes_t b, output words_t e);
        for (int w = 0; w < DEPTH; w++) begin
            e[w].addr = AW'(w);
            e[w].word = {b[2*w+1], b[2*w]};
        end
    endtask

    function automatic logic [DW-1:0] xor_all(input bytes_t b);
        logic [DW-1:0] x;
        x = '0;
        for (int i = 0; i < NBYTES; i++) x ^= b[i];
        return x;
    endfunction

    // Receiver handshake: start pulse, some bit-times, then data with ready.
    task automatic send_byte(input logic [DW-1:0] val, input logic exp_wr);
        @(negedge clk);
        rx_ready    = 1'b0;
        rx_new_byte = 1'b1;
        @(negedge clk);
        rx_new_byte = 1'b0;
        repeat ($urandom_range(3, 0)) @(negedge clk);
        rx_data  = val;
        rx_ready = 1'b1;
        @(negedge clk);
        check("wr_latency", {31'd0, mem_wr_en}, {31'd0, exp_wr});
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start_load = 1'b1;
        @(negedge clk);
        start_load = 1'b0;
    endtask

    // Full load from IDLE/DONE; mid_start >= 0 inserts an ignored start_load
    // before that byte. The trailer is consumed by CHECK in the checksum
    // build and must be ignored in DONE otherwise.
    task automatic do_load(input bytes_t b, input words_t e, input logic [DW-1:0] trailer,
                           input int mid_start);
        logic exp_chk;
        exp_chk = 1'b0;
`ifdef LOADER_CHECKSUM_EN
        exp_chk = (trailer != xor_all(b));
`endif
        pulse_start();
        check("busy_after_start", {31'd0, busy}, 32'd1);
        check("done_cleared", {31'd0, done}, 32'd0);
        check("chk_err_cleared", {31'd0, chk_err}, 32'd0);
        for (int w = 0; w < DEPTH; w++) exp_q.push_back(e[w]);
        for (int i = 0; i < NBYTES; i++) begin
            if (i == mid_start) begin
                pulse_start();
                check("busy_mid_start", {31'd0, busy}, 32'd1);
            end
            send_byte(b[i], (i % 2) == 1);
        end
        send_byte(trailer, 1'b0);
        @(negedge clk);
        check("busy_end", {31'd0, busy}, 32'd0);
        check("done_end", {31'd0, done}, 32'd1);
        check("chk_err_end", {31'd0, chk_err}, {31'd0, exp_chk});
        check("writes_pending", exp_q.size(), 32'd0);
        check("addr_hold", {20'd0, mem_addr}, {20'd0, e[DEPTH-1].addr});
        check("data_hold", {16'd0, mem_wr_data}, {16'd0, e[DEPTH-1].word});
    endtask

    initial begin
        vec_t   tbl[DEPTH];
        bytes_t b;
        words_t e;
        int     seen0;

        tbl[0] = '{lo: 8'h34, hi: 8'h12, addr: 12'h0, word: 16'h1234};
        tbl[1] = '{lo: 8'h78, hi: 8'h56, addr: 12'h1, word: 16'h5678};
        tbl[2] = '{lo: 8'hBC, hi: 8'h9A, addr: 12'h2, word: 16'h9ABC};
        tbl[3] = '{lo: 8'hF0, hi: 8'hDE, addr: 12'h3, word: 16'hDEF0};

        repeat (3) @(negedge clk);
        check("rst_wr_en", {31'd0, mem_wr_en}, 32'd0);
        check("rst_addr", {20'd0, mem_addr}, 32'd0);
        check("rst_data", {16'd0, mem_wr_data}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_chk_err", {31'd0, chk_err}, 32'd0);
        rstN = 1'b1;
        @(negedge clk);

        // Bytes before any start_load are ignored in IDLE.
        seen0 = wr_seen;
        for (int i = 0; i < 4; i++) send_byte(8'(8'h11 * (i + 1)), 1'b0);
        @(negedge clk);
        check("idle_busy", {31'd0, busy}, 32'd0);
        check("idle_done", {31'd0, done}, 32'd0);
        check("idle_writes", wr_seen - seen0, 32'd0);

        // Fixed vector table, bad trailer first then good trailer; the second
        // load also starts from DONE with chk_err possibly set.
        for (int i = 0; i < DEPTH; i++) begin
            b[2*i]   = tbl[i].lo;
            b[2*i+1] = tbl[i].hi;
            e[i]     = '{addr: tbl[i].addr, word: tbl[i].word};
        end
        do_load(b, e, 8'hFF, -1);
        do_load(b, e, 8'h00, -1);

        // Reset after three bytes: one word written, second word partial.
        pulse_start();
        exp_q.push_back('{addr: 12'h0, word: 16'h5AA5});
        send_byte(8'hA5, 1'b0);
        send_byte(8'h5A, 1'b1);
        send_byte(8'h33, 1'b0);
        @(negedge clk);
        #2 rstN = 1'b0;
        #1;
        check("arst_wr_en", {31'd0, mem_wr_en}, 32'd0);
        check("arst_data", {16'd0, mem_wr_data}, 32'd0);
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_done", {31'd0, done}, 32'd0);
        check("arst_pending", exp_q.size(), 32'd0);
        @(negedge clk);
        rstN = 1'b1;
        @(negedge clk);
        check("arst_idle_busy", {31'd0, busy}, 32'd0);
        for (int i = 0; i < NBYTES; i++) b[i] = 8'($urandom);
        model_load(b, e);
        do_load(b, e, xor_all(b), -1);

        // start_load between bytes 2 and 3 must not disturb the load.
        for (int i = 0; i < NBYTES; i++) b[i] = 8'($urandom);
        model_load(b, e);
        do_load(b, e, xor_all(b), 2);

        // Randomized loads back to back from DONE.
        for (int r = 0; r < 6; r++) begin
            logic [DW-1:0] tr;
            for (int i = 0; i < NBYTES; i++) b[i] = 8'($urandom);
            model_load(b, e);
            tr = ($urandom_range(1, 0) == 1) ? xor_all(b) : 8'($urandom);
            do_load(b, e, tr, (r % 2 == 1) ? int'($urandom_range(NBYTES - 1, 1)) : -1);
        end

        check("final_pending", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
